// File: rtl/poly_horner_seq.sv
`default_nettype none
// ============================================================================
//  Module   : poly_horner_seq
//  Purpose  : Sequential polynomial evaluator. Computes
//             P(x) = sum c[i]*x^i by Horner's rule, one coefficient per
//             clock, on a single shared multiply-accumulate unit.
//  Ports    : clk          rising-edge clock
//             rst          asynchronous active-high reset
//             coeff_we     coefficient write enable (honoured only in IDLE)
//             coeff_addr   coefficient index (0 = constant term)
//             coeff_wdata  signed coefficient value
//             x            signed evaluation point, sampled on start accept
//             start        request an evaluation (ignored while busy)
//             busy         high whenever the FSM is not IDLE
//             done         one-cycle pulse; sum and ovf are valid
//             sum          signed result, held until the next done
//             ovf          an intermediate step overflowed signed SW range
//  Revision : 1.0  initial release
// ============================================================================
module poly_horner_seq #(
    parameter int DEGREE = 10,
    parameter int XW     = 16,
    parameter int CW     = 16,
    parameter int SW     = 32,
    parameter int AW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coeff_we,
    input  logic [AW-1:0]        coeff_addr,
    input  logic signed [CW-1:0] coeff_wdata,
    input  logic signed [XW-1:0] x,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic signed [SW-1:0] sum,
    output logic                 ovf
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [AW-1:0] c_deg_addr = AW'(DEGREE);
    // First coefficient consumed in RUN; unused when DEGREE is zero.
    localparam logic [AW-1:0] c_idx_init = (DEGREE > 0) ? AW'(DEGREE - 1) : '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic signed [CW-1:0]  r_coeff [0:DEGREE];
    logic signed [XW-1:0]  r_x;
    logic signed [SW-1:0]  r_acc;
    logic [AW-1:0]         r_idx;
    logic signed [SW-1:0]  r_sum;
    logic                  r_ovf;
    // Overflow accumulated over the current run; published to ovf on done so
    // the visible flag keeps the previous result until then.
    logic                  r_ovf_run;

    // ------------------------------------------------------------------------
    // Multiply-accumulate datapath
    // ------------------------------------------------------------------------
    logic signed [SW+XW-1:0] w_prod_full;
    logic signed [SW-1:0]    w_prod;
    logic                    w_prod_ovf;
    logic signed [CW-1:0]    w_coef;
    logic signed [SW-1:0]    w_coef_ext;
    logic signed [SW-1:0]    w_top_ext;
    logic signed [SW-1:0]    w_mac;
    logic                    w_add_ovf;
    logic                    w_last;
    logic                    w_wr_ok;

    // Both operands are signed, so the multiply is evaluated exactly at the
    // full SW+XW width of the destination.
    assign w_prod_full = r_acc * r_x;
    assign w_prod      = w_prod_full[SW-1:0];
    // Exact product fits in SW bits only if the discarded high bits are a
    // pure sign extension of the kept result.
    assign w_prod_ovf  = (w_prod_full != {{XW{w_prod[SW-1]}}, w_prod});

    assign w_coef      = r_coeff[r_idx];
    assign w_coef_ext  = {{(SW-CW){w_coef[CW-1]}}, w_coef};
    assign w_top_ext   = {{(SW-CW){r_coeff[DEGREE][CW-1]}}, r_coeff[DEGREE]};

    assign w_mac       = w_prod + w_coef_ext;
    // Signed add overflow: operands share a sign that the result lacks.
    assign w_add_ovf   = (w_prod[SW-1] == w_coef_ext[SW-1]) &&
                         (w_mac[SW-1] != w_prod[SW-1]);

    assign w_last      = (r_idx == '0);
    assign w_wr_ok     = coeff_we && (coeff_addr <= c_deg_addr);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                busy = 1'b0;
                if (start) begin
                    // A degree-zero polynomial needs no MAC steps.
                    w_state_nxt = (DEGREE == 0) ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and coefficient register file
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DEGREE; i++) begin
                r_coeff[i] <= '0;
            end
            r_x       <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_sum     <= '0;
            r_ovf     <= 1'b0;
            r_ovf_run <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        // Start takes priority; a simultaneous write is dropped.
                        r_x       <= x;
                        r_acc     <= w_top_ext;
                        r_idx     <= c_idx_init;
                        r_ovf_run <= 1'b0;
                        if (DEGREE == 0) begin
                            r_sum <= w_top_ext;
                            r_ovf <= 1'b0;
                        end
                    end else if (w_wr_ok) begin
                        r_coeff[coeff_addr] <= coeff_wdata;
                    end
                end
                c_st_run: begin
                    r_acc     <= w_mac;
                    r_ovf_run <= r_ovf_run | w_prod_ovf | w_add_ovf;
                    if (w_last) begin
                        r_sum <= w_mac;
                        r_ovf <= r_ovf_run | w_prod_ovf | w_add_ovf;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum = r_sum;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_poly_horner_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_horner_seq
//  Purpose  : Self-checking bench for poly_horner_seq. Stimulus pushes the
//             expected result of each accepted evaluation into a scoreboard;
//             a monitor pops and compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly_horner_seq;

    localparam int DEG = 10;

    logic               clk;
    logic               rst;
    logic               coeff_we;
    logic [3:0]         coeff_addr;
    logic signed [15:0] coeff_wdata;
    logic signed [15:0] x;
    logic               start;
    logic               busy;
    logic               done;
    logic signed [31:0] sum;
    logic               ovf;

    poly_horner_seq #(
        .DEGREE (DEG),
        .XW     (16),
        .CW     (16),
        .SW     (32),
        .AW     (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .x           (x),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint esum;
        bit     eovf;
        int     acc_cyc;
    } exp_t;

    exp_t   sb[$];
    longint coef[0:DEG];
    longint held_sum = 0;
    bit     held_ovf = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrap32(input longint v);
        int t;
        t = int'(v);
        return longint'(t);
    endfunction

    function automatic bit out32(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Reference: Horner evaluation in 64-bit arithmetic, each step wrapped
    // to 32 bits, flagging any exact intermediate outside the 32-bit range.
    task automatic model(input longint xv, output longint s, output bit o);
        longint acc;
        longint p;
        longint t;
        acc = coef[DEG];
        o   = 1'b0;
        for (int i = DEG - 1; i >= 0; i--) begin
            p = acc * xv;
            if (out32(p)) o = 1'b1;
            p = wrap32(p);
            t = p + coef[i];
            if (out32(t)) o = 1'b1;
            acc = wrap32(t);
        end
        s = acc;
    endtask

    // Write issued only while the DUT is known idle.
    task automatic wr(input int addr, input longint data);
        @(negedge clk);
        coeff_we    = 1'b1;
        coeff_addr  = 4'(addr);
        coeff_wdata = 16'(data);
        if (addr <= DEG) coef[addr] = longint'(coeff_wdata);
        @(posedge clk);
        #1;
        coeff_we = 1'b0;
    endtask

    // Issue a start (optionally with a colliding write that must be dropped),
    // push the expected result, and check that sum/ovf hold over acceptance.
    task automatic start_eval(input longint xv, input bit with_we);
        exp_t   e;
        longint s;
        bit     o;
        @(negedge clk);
        x     = 16'(xv);
        start = 1'b1;
        if (with_we) begin
            coeff_we    = 1'b1;
            coeff_addr  = 4'd0;
            coeff_wdata = 16'sd7;
        end
        model(longint'(x), s, o);
        e.esum    = s;
        e.eovf    = o;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        coeff_we = 1'b0;
        chk("sum_held_on_accept", longint'(sum), held_sum);
        chk("ovf_held_on_accept", longint'(ovf), longint'(held_ovf));
        held_sum = s;
        held_ovf = o;
    endtask

    // Let the run finish while scrambling x, which must not matter.
    task automatic wait_run();
        repeat (DEG + 1) begin
            @(negedge clk);
            x = 16'($urandom);
        end
    endtask

    task automatic load_basic();
        wr(0, -1);
        wr(1, 1);
        wr(2, 1);
        for (int i = 3; i <= DEG; i++) wr(i, 0);
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", longint'(cyc - e.acc_cyc), longint'(DEG));
                    chk("sum", longint'(sum), e.esum);
                    chk("ovf", longint'(ovf), longint'(e.eovf));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        longint xv;
        for (int i = 0; i <= DEG; i++) coef[i] = 0;
        rst = 1'b1; coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0;
        x = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_sum",  longint'(sum), 0);
        chk("reset_ovf",  longint'(ovf), 0);
        rst = 1'b0;

        // Basic polynomial, latency and busy length.
        load_basic();
        start_eval(-2, 1'b0);
        bc = 0;
        for (int i = 0; i < DEG + 2; i++) begin
            bc += int'(busy);
            @(negedge clk);
        end
        chk("busy_cycles", longint'(bc), longint'(DEG + 1));

        start_eval(1, 1'b0);  wait_run();
        wr(0, 5);
        start_eval(0, 1'b0);  wait_run();

        // Overflow, then sticky flag cleared by a clean run.
        for (int i = 0; i < DEG; i++) wr(i, 0);
        wr(DEG, 1);
        start_eval(8, 1'b0);  wait_run();
        start_eval(16, 1'b0); wait_run();
        start_eval(-1, 1'b0); wait_run();

        // Start and write during a run are ignored.
        load_basic();
        start_eval(-2, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; coeff_we = 1'b1; coeff_addr = 4'd0; coeff_wdata = 16'sd7;
        @(negedge clk);
        start = 1'b0; coeff_we = 1'b0;
        wait_run();
        start_eval(-2, 1'b0); wait_run();
        // Start with a simultaneous write in IDLE: write dropped.
        start_eval(3, 1'b1);  wait_run();
        start_eval(0, 1'b0);  wait_run();

        // Asynchronous reset in the middle of a run.
        start_eval(3, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", longint'(busy), 0);
        chk("async_rst_done", longint'(done), 0);
        chk("async_rst_sum",  longint'(sum), 0);
        chk("async_rst_ovf",  longint'(ovf), 0);
        sb.delete();
        for (int i = 0; i <= DEG; i++) coef[i] = 0;
        held_sum = 0;
        held_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_eval(5, 1'b0);  wait_run();

        // Out-of-range writes are no-ops.
        wr(15, 3);
        wr(11, 3);
        start_eval(2, 1'b0);  wait_run();

        // Randomized runs.
        for (int n = 0; n < 30; n++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 1) == 1)
                    wr($urandom_range(0, 15), longint'($signed(16'($urandom))));
                else
                    wr($urandom_range(0, DEG), longint'($urandom_range(0, 6)) - 3);
            end
            if ($urandom_range(0, 2) == 0)
                xv = longint'($signed(16'($urandom)));
            else
                xv = longint'($urandom_range(0, 8)) - 4;
            start_eval(xv, ($urandom_range(0, 4) == 0));
            wait_run();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
